// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two framed byte streams.
// Grants whole frames, registers the output stream and revokes stalled grants after a timeout.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_last,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_last,
    output logic                  req1_ready,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ready,
    output logic [1:0]            grant,
    output logic [1:0]            abort,
    input  logic [1:0]            abort_clr,
    output logic [CNT_WIDTH-1:0]  beat_cnt0,
    output logic [CNT_WIDTH-1:0]  beat_cnt1
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t                state, state_next;
    logic                  rr_ptr, rr_ptr_next;
    logic [IDLE_W-1:0]     idle_cnt, idle_cnt_next;
    logic [1:0]            abort_set;
    logic [1:0]            grant_next;
    logic                  out_free;
    logic                  accept0, accept1, accept;
    logic                  cur_valid, cur_last;
    logic [DATA_WIDTH-1:0] cur_data;

    // The output register can take a new byte when empty or draining this cycle.
    always_comb begin
        out_free   = !tx_valid || tx_ready;
        req0_ready = (state == GRANT0) && out_free;
        req1_ready = (state == GRANT1) && out_free;
        accept0    = req0_valid && req0_ready;
        accept1    = req1_valid && req1_ready;
        accept     = accept0 || accept1;
        if (state == GRANT1) begin
            cur_valid = req1_valid;
            cur_last  = req1_last;
            cur_data  = req1_data;
        end else begin
            cur_valid = req0_valid;
            cur_last  = req0_last;
            cur_data  = req0_data;
        end
    end

    always_comb begin
        state_next    = state;
        rr_ptr_next   = rr_ptr;
        idle_cnt_next = idle_cnt;
        abort_set     = 2'b00;
        case (state)
            IDLE: begin
                idle_cnt_next = '0;
                if (req0_valid && req1_valid) begin
                    state_next = rr_ptr ? GRANT1 : GRANT0;
                end else if (req0_valid) begin
                    state_next = GRANT0;
                end else if (req1_valid) begin
                    state_next = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                // Only cycles with no offered beat count towards the timeout; backpressure does not.
                if (accept) begin
                    idle_cnt_next = '0;
                    if (cur_last) begin
                        state_next  = IDLE;
                        rr_ptr_next = (state == GRANT0);
                    end
                end else if (!cur_valid) begin
                    if (idle_cnt == IDLE_MAX) begin
                        state_next  = IDLE;
                        rr_ptr_next = (state == GRANT0);
                        abort_set   = (state == GRANT0) ? 2'b01 : 2'b10;
                    end else begin
                        idle_cnt_next = idle_cnt + IDLE_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (state_next)
            GRANT0:  grant_next = 2'b01;
            GRANT1:  grant_next = 2'b10;
            default: grant_next = 2'b00;
        endcase
    end

    // A timeout that sets an abort bit wins over a same-cycle clear of that bit.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            idle_cnt  <= '0;
            grant     <= 2'b00;
            abort     <= 2'b00;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            beat_cnt0 <= '0;
            beat_cnt1 <= '0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_ptr_next;
            idle_cnt <= idle_cnt_next;
            grant    <= grant_next;
            abort    <= abort_set | (abort & ~abort_clr);
            if (accept) begin
                tx_data  <= cur_data;
                tx_valid <= 1'b1;
            end else if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end
            if (accept0 && (beat_cnt0 != '1)) begin
                beat_cnt0 <= beat_cnt0 + CNT_WIDTH'(1);
            end
            if (accept1 && (beat_cnt1 != '1)) begin
                beat_cnt1 <= beat_cnt1 + CNT_WIDTH'(1);
            end
        end
    end

endmodule
